four_12_12_delta: RTL
=====================

# four_12_12_delta

Downstream consumer of the stage-3 error stream. Takes each `stage_3_error` beat (`float_24_8`), applies a power-of-two learning-rate scale by exponent adjustment with saturation and flush-to-zero, and emits the result as `stage_3_delta` for the back-propagation path. A 2-entry output buffer provides full-throughput valid/ready decoupling. Frame and sample statistics are tracked from the `_fst` markers.

## Interface

Parameters:
- `CNT_W`, default 16: width of the frame and sample counters.
- `CLIP_EXP`, default 0: clip exponent limit. Used only when `FOUR_12_12_DELTA_CLIP_EN` is defined.

Ports:
- `clk` in, 1: the single clock.
- `reset` in, 1: asynchronous, active-low. All state clears while low.
- `stage_3_error` in, 32: `float_24_8` error beat.
- `stage_3_error_fst` in, 1: first beat of a frame.
- `stage_3_error_vld` in, 1: input valid.
- `stage_3_error_rdy` out, 1: input ready.
- `lr_shift` in, 8: signed learning-rate exponent shift. Sampled on fst beats.
- `stage_3_delta` out, 32: scaled `float_24_8`.
- `stage_3_delta_fst` out, 1: fst carried through from the input beat.
- `stage_3_delta_vld` out, 1: output valid.
- `stage_3_delta_rdy` in, 1: output ready.
- `frame_count` out, CNT_W: number of fst beats accepted. Saturates at all-ones.
- `sample_count` out, CNT_W: beats accepted in the current frame. Saturates.
- `last_frame_len` out, CNT_W: `sample_count` value at the moment the most recent frame closed.
- `sat_flag` out, 1: sticky. Set when any exponent overflowed.
- `clip_count` out, CNT_W: number of clipped beats. Port exists only with `FOUR_12_12_DELTA_CLIP_EN`.

## Operation

Format:
- `float_24_8` is {man: signed 24 bits [31:8], exp: signed 8 bits [7:0]}.
- Value = man·2^exp.

Input handshake:
- A beat is accepted when `vld & rdy`.
- `stage_3_error_rdy` = buffer not full. It is driven from a registered count, with no combinational path from `stage_3_delta_rdy`.

Shift selection:
- On an fst beat, the effective shift is the current `lr_shift` input, and it is latched.
- On a non-fst beat, the effective shift is the latched value. The latch resets to 0.

Scale, computed with a 9-bit signed sum s = exp + shift:
- If man == 0: output is {0, 0}, regardless of the shift.
- If s > 127: output exp = 127, man = +0x7FFFFF if man ≥ 0, else −0x800000. Set `sat_flag`.
- If s < −128: output is {0, 0} (flush).
- Otherwise: output is {man, s[7:0]}.
- Clip (macro only) is applied after the scale step.

Statistics, updated on each accepted beat:
- fst beat: if `frame_count` ≠ 0, then `last_frame_len` ← `sample_count`. Also `sample_count` ← 1 and `frame_count` += 1.
- Non-fst beat: `sample_count` += 1.
- Beats that arrive before the first fst are scaled with shift 0 and counted in `sample_count`. `frame_count` stays 0.
- All counters saturate at 2^CNT_W − 1 and do not wrap.

## Timing

- Reset values: all outputs are 0, except `stage_3_error_rdy` = 1 once reset deasserts. The buffer is empty and the shift latch is 0.
- Latency: a beat accepted in cycle N into an empty buffer shows `stage_3_delta_vld` = 1 in cycle N+1.
- Throughput: 1 beat/cycle while `stage_3_delta_rdy` = 1.
- Buffer depth is 2.
- Full boundary: with 2 entries held and no output pop, `stage_3_error_rdy` = 0 in the following cycle.
- Simultaneous push and pop while full: not possible, because rdy = 0 when full.
- Simultaneous push and pop with 1 entry held: count stays 1, data advances.
- Empty boundary: with 0 entries, `stage_3_delta_vld` = 0. There is no bypass; minimum latency is 1 cycle.
- Output stability: while `vld & !rdy`, `stage_3_delta`, `_fst` and `vld` hold stable.
- Statistics update in the cycle after acceptance.
- Reset asserted mid-frame: buffered beats are discarded, and counters, `sat_flag` and the shift latch clear immediately.

## Configuration

`FOUR_12_12_DELTA_CLIP_EN`:
- Defined: after scaling, any beat with exp > `CLIP_EXP` is forced to exp = `CLIP_EXP`, man = ±max (sign preserved). Each such beat increments `clip_count`, which saturates. The `clip_count` port is present.
- Undefined: no clip stage, no `clip_count` port. Only the exponent-127 saturation applies.

## Structure

- Shared types package holds:
  - the `float_24_8` typedef, which the error stage already uses;
  - constants `FLOAT_MAN_MAX` = 24'h7FFFFF and `FLOAT_MAN_MIN` = 24'h800000;
  - `FLOAT_EXP_MAX` = 127 and `FLOAT_EXP_MIN` = −128.
- Sub-module `four_12_12_delta_buf`: a 2-entry valid/ready buffer, 33 bits wide (data plus fst), with registered ready.
- The top level holds the scale/clip logic, the shift latch and the statistics.

## Test plan

- Scale: beat man = 0x000100, exp = 5, fst, `lr_shift` = −3 → delta {0x000100, 2}, fst = 1. The next non-fst beat, sent with `lr_shift` changed to 7, still uses −3.
- Saturate and flush:
  - exp = 120, shift = 10, man negative → {0x800000, 127}, `sat_flag` = 1 and stays 1.
  - exp = −125, shift = −10 → {0, 0}.
- Backpressure: stream 6 beats with `stage_3_delta_rdy` low for cycles 2–5 → `stage_3_error_rdy` drops after 2 beats are held. All 6 beats arrive in order, none lost or duplicated, and data holds stable while stalled.
- Statistics: frames of 4, 3 and 5 beats → `frame_count` = 3, `last_frame_len` = 3, `sample_count` = 5.
- Reset mid-stream: assert `reset` low with 2 beats buffered → `vld` = 0 and counters = 0 immediately. The first post-reset beat emerges 1 cycle after acceptance.
- Clip (macro defined, `CLIP_EXP` = 0): man = 0x001000, exp = 4, shift = 0 → {0x7FFFFF, 0}, `clip_count` = 1.

Source files
------------

// File: rtl/four_12_12_delta_pkg.sv
// four_12_12_delta_pkg: shared float_24_8 type and format limits for the delta stage.
package four_12_12_delta_pkg;
  typedef struct packed {
    logic signed [23:0] man;
    logic signed [7:0]  exp;
  } float_24_8;
  localparam logic [23:0] FLOAT_MAN_MAX = 24'h7FFFFF;
  localparam logic [23:0] FLOAT_MAN_MIN = 24'h800000;
  localparam logic [7:0]  FLOAT_EXP_MAX = 8'h7F;
  localparam logic [7:0]  FLOAT_EXP_MIN = 8'h80;
endpackage

// File: rtl/four_12_12_delta_buf.sv
// four_12_12_delta_buf: 2-entry valid/ready buffer, ready driven from the registered count.
// Ports: clk, reset (async active-low), in_data/in_vld/in_rdy (push side),
//        out_data/out_vld/out_rdy (pop side, head entry held stable while stalled).
module four_12_12_delta_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic [32:0] in_data,
  input  logic        in_vld,
  output logic        in_rdy,
  output logic [32:0] out_data,
  output logic        out_vld,
  input  logic        out_rdy
);
  logic [32:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        push, pop;
  assign in_rdy   = cnt_q != 2'd2;
  assign out_vld  = cnt_q != 2'd0;
  assign out_data = e0_q;
  assign push     = in_vld & in_rdy;
  assign pop      = out_vld & out_rdy;
  // Head refills from the second slot when full, otherwise straight from the input.
  always_comb begin
    e0_d  = (pop && cnt_q == 2'd2) ? e1_q : (push && (cnt_q == 2'd0 || pop)) ? in_data : e0_q;
    e1_d  = (push && !pop && cnt_q == 2'd1) ? in_data : e1_q;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= '0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/four_12_12_delta.sv
// four_12_12_delta: power-of-two learning-rate scaling of the stage-3 error stream into stage_3_delta.
// Ports: clk, reset (async active-low); stage_3_error/_fst/_vld/_rdy input stream; lr_shift
//        (signed, sampled on fst beats); stage_3_delta/_fst/_vld/_rdy output stream; frame_count,
//        sample_count, last_frame_len statistics; sat_flag sticky overflow; clip_count with
//        FOUR_12_12_DELTA_CLIP_EN (optional exponent clip to CLIP_EXP).
module four_12_12_delta
  import four_12_12_delta_pkg::*;
#(
  parameter int CNT_W = 16
`ifdef FOUR_12_12_DELTA_CLIP_EN
  , parameter int CLIP_EXP = 0
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      stage_3_error,
  input  logic             stage_3_error_fst,
  input  logic             stage_3_error_vld,
  output logic             stage_3_error_rdy,
  input  logic [7:0]       lr_shift,
  output logic [31:0]      stage_3_delta,
  output logic             stage_3_delta_fst,
  output logic             stage_3_delta_vld,
  input  logic             stage_3_delta_rdy,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] last_frame_len,
  output logic             sat_flag
`ifdef FOUR_12_12_DELTA_CLIP_EN
  , output logic [CNT_W-1:0] clip_count
`endif
);
  float_24_8         in_f, sc, res;
  logic [7:0]        shift_q, shift_d, sh;
  logic signed [8:0] s;
  logic              ovf, unf, acc, sat_q, sat_d;
  logic [CNT_W-1:0]  frame_q, frame_d, sample_q, sample_d, last_q, last_d;
  logic [32:0]       out_data;
  assign in_f = stage_3_error;
  assign acc  = stage_3_error_vld & stage_3_error_rdy;
  assign sh   = stage_3_error_fst ? lr_shift : shift_q;
  // Sign-extended 9-bit sum so exponent overflow and underflow are both visible.
  assign s    = $signed({in_f.exp[7], in_f.exp}) + $signed({sh[7], sh});
  assign ovf  = in_f.man != '0 && s > $signed({FLOAT_EXP_MAX[7], FLOAT_EXP_MAX});
  assign unf  = s < $signed({FLOAT_EXP_MIN[7], FLOAT_EXP_MIN});
  always_comb begin
    sc = (in_f.man == '0 || unf) ? '0
       : ovf ? {(in_f.man[23] ? FLOAT_MAN_MIN : FLOAT_MAN_MAX), FLOAT_EXP_MAX}
       : {in_f.man, s[7:0]};
  end
`ifdef FOUR_12_12_DELTA_CLIP_EN
  localparam logic signed [7:0] CLIP_E = CLIP_EXP[7:0];
  logic             clip;
  logic [CNT_W-1:0] clip_q, clip_d;
  assign clip = sc.exp > CLIP_E;
  assign res  = clip ? {(sc.man[23] ? FLOAT_MAN_MIN : FLOAT_MAN_MAX), CLIP_E} : sc;
  assign clip_d = (acc && clip && !(&clip_q)) ? clip_q + 1'b1 : clip_q;
  assign clip_count = clip_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) clip_q <= '0;
    else        clip_q <= clip_d;
  end
`else
  assign res = sc;
`endif
  always_comb begin
    shift_d  = (acc && stage_3_error_fst) ? lr_shift : shift_q;
    sat_d    = sat_q | (acc & ovf);
    frame_d  = (acc && stage_3_error_fst && !(&frame_q)) ? frame_q + 1'b1 : frame_q;
    last_d   = (acc && stage_3_error_fst && frame_q != '0) ? sample_q : last_q;
    sample_d = !acc ? sample_q : stage_3_error_fst ? CNT_W'(1) : (&sample_q) ? sample_q : sample_q + 1'b1;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q  <= '0;
      sat_q    <= 1'b0;
      frame_q  <= '0;
      sample_q <= '0;
      last_q   <= '0;
    end else begin
      shift_q  <= shift_d;
      sat_q    <= sat_d;
      frame_q  <= frame_d;
      sample_q <= sample_d;
      last_q   <= last_d;
    end
  end
  assign sat_flag       = sat_q;
  assign frame_count    = frame_q;
  assign sample_count   = sample_q;
  assign last_frame_len = last_q;
  assign {stage_3_delta, stage_3_delta_fst} = out_data;
  four_12_12_delta_buf u_buf (
    .clk      (clk),
    .reset    (reset),
    .in_data  ({res, stage_3_error_fst}),
    .in_vld   (stage_3_error_vld),
    .in_rdy   (stage_3_error_rdy),
    .out_data (out_data),
    .out_vld  (stage_3_delta_vld),
    .out_rdy  (stage_3_delta_rdy)
  );
endmodule
